// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit master.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StRmwRd,
    StRmwWr,
    StWrLo,
    StWrHi,
    StResp
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Every non-double access touches a full 32-bit word of memory.
  localparam int unsigned FootNarrow = 4;
  localparam int unsigned FootDouble = 8;

  function automatic logic out_of_range(input logic [63:0] addr, input logic [1:0] size,
                                        input int unsigned mem_bytes);
    logic [63:0] foot;
    foot = (size == SZ_D) ? 64'(FootDouble) : 64'(FootNarrow);
    return addr > (64'(mem_bytes) - foot);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load sign/zero extension and store byte/half merge into a read word.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [15:0] wdata_i,
  output logic [63:0] load_data_o,
  output logic [31:0] merge_data_o
);

  always_comb begin
    load_data_o = '0;
    unique case (size_i)
      SZ_B:    load_data_o = {{56{~unsigned_i & lo_i[7]}}, lo_i[7:0]};
      SZ_H:    load_data_o = {{48{~unsigned_i & lo_i[15]}}, lo_i[15:0]};
      SZ_W:    load_data_o = {{32{~unsigned_i & lo_i[31]}}, lo_i};
      SZ_D:    load_data_o = {hi_i, lo_i};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merge_data_o = lo_i;
    if (size_i == SZ_B) begin
      merge_data_o = {lo_i[31:8], wdata_i[7:0]};
    end else if (size_i == SZ_H) begin
      merge_data_o = {lo_i[31:16], wdata_i};
    end
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit master: sequences byte..double accesses over a 32-bit-per-beat memory port.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic [63:0] mem_add_o,
  output logic [63:0] write_data_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [63:0] read_data_i
);

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  logic [63:0] load_data;
  logic [31:0] merge_data;
  logic        unused_read_hi;

  assign unused_read_hi = ^read_data_i[63:32];

  lsu_extend u_extend (
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .lo_i         (lo_q),
    .hi_i         (hi_q),
    .wdata_i      (wdata_q[15:0]),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    write_d      = write_q;
    uns_d        = uns_q;
    err_d        = err_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_add_o    = '0;
    write_data_o = '0;
    rsp_valid_o  = 1'b0;
    rsp_rdata_o  = '0;
    rsp_err_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          write_d = req_write_i;
          uns_d   = req_unsigned_i;
          lo_d    = '0;
          hi_d    = '0;
          err_d   = out_of_range(req_addr_i, req_size_i, MEM_BYTES);
          if (err_d) begin
            state_d = StResp;
          end else if (!req_write_i) begin
            state_d = StRdLo;
          end else if (req_size_i == SZ_W || req_size_i == SZ_D) begin
            state_d = StWrLo;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRdLo: begin
        mem_read_o = 1'b1;
        mem_add_o  = addr_q;
        lo_d       = read_data_i[31:0];
        state_d    = (size_q == SZ_D) ? StRdHi : StResp;
      end
      StRdHi: begin
        mem_read_o = 1'b1;
        mem_add_o  = addr_q + 64'd4;
        hi_d       = read_data_i[31:0];
        state_d    = StResp;
      end
      StRmwRd: begin
        mem_read_o = 1'b1;
        mem_add_o  = addr_q;
        lo_d       = read_data_i[31:0];
        state_d    = StRmwWr;
      end
      StRmwWr: begin
        mem_write_o  = 1'b1;
        mem_add_o    = addr_q;
        write_data_o = {32'd0, merge_data};
        state_d      = StResp;
      end
      StWrLo: begin
        mem_write_o  = 1'b1;
        mem_add_o    = addr_q;
        write_data_o = {32'd0, wdata_q[31:0]};
        state_d      = (size_q == SZ_D) ? StWrHi : StResp;
      end
      StWrHi: begin
        mem_write_o  = 1'b1;
        mem_add_o    = addr_q + 64'd4;
        write_data_o = {32'd0, wdata_q[63:32]};
        state_d      = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (err_q || write_q) ? 64'd0 : load_data;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Randomized and directed bench for lsu_master against a byte-array memory reference model.
module tb_lsu_master;

  localparam int unsigned MemBytes = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [63:0] mem_add;
  logic [63:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] read_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  tb_mem  [MemBytes];
  logic [7:0]  ref_mem [MemBytes];
  logic        init_mem = 1'b1;
  logic [63:0] wlog_a[$];
  logic [63:0] wlog_d[$];

  always #5 clk = ~clk;

  lsu_master #(
    .MEM_BYTES (MemBytes)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy),
    .mem_add_o      (mem_add),
    .write_data_o   (write_data),
    .mem_write_o    (mem_write),
    .mem_read_o     (mem_read),
    .read_data_i    (read_data)
  );

  // Environment memory: combinational read, word write on the clock edge.
  always_comb begin
    read_data = '0;
    if (mem_add < 64'(MemBytes - 3)) begin
      for (int k = 0; k < 4; k++) read_data[8*k +: 8] = tb_mem[int'(mem_add[8:0]) + k];
    end
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < int'(MemBytes); i++) tb_mem[i] <= 8'd0;
    end else if (mem_write) begin
      wlog_a.push_back(mem_add);
      wlog_d.push_back(write_data);
      if (mem_add < 64'(MemBytes - 3)) begin
        for (int k = 0; k < 4; k++) tb_mem[int'(mem_add[8:0]) + k] <= write_data[8*k +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_bytes(input logic [63:0] a, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (a + 64'(k) < 64'(MemBytes)) v[8*k +: 8] = ref_mem[int'(a[8:0]) + k];
    end
    return v;
  endfunction

  function automatic logic [63:0] dut_word(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (a + 64'(k) < 64'(MemBytes)) v[8*k +: 8] = tb_mem[int'(a[8:0]) + k];
    end
    return v;
  endfunction

  // Load value as an ISA defines it: n bytes little-endian, then sign/zero extended.
  function automatic logic [63:0] model_load(input logic [1:0] sz, input logic u,
                                             input logic [63:0] a);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = ref_bytes(a, n);
    if (n < 8 && !u && v[8*n-1]) begin
      for (int k = 8 * n; k < 64; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, output logic [63:0] rd);
    logic        exp_err, got, g_err;
    logic [63:0] exp_rd;
    int          exp_lat, exp_acc, lat, acc, n;
    n       = 1 << sz;
    exp_err = a > 64'(int'(MemBytes) - ((n == 8) ? 8 : 4));
    exp_acc = exp_err ? 0 : (n == 8 || (w && n < 4)) ? 2 : 1;
    exp_lat = exp_acc + 1;
    exp_rd  = (exp_err || w) ? 64'd0 : model_load(sz, u, a);
    @(negedge clk);
    check_val("ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; acc = 0; got = 1'b0; g_err = 1'b0; rd = '0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      check_val("busy", 64'(busy), 64'd1);
      check_val("rd_wr_excl", 64'(mem_read & mem_write), 64'd0);
      if (mem_read || mem_write) acc++;
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; g_err = rsp_err;
      end
    end
    if (!got) check_val("rsp_timeout", 64'd0, 64'd1);
    check_val("rsp_err", 64'(g_err), 64'(exp_err));
    check_val("rsp_rdata", rd, exp_rd);
    check_val("latency", 64'(lat), 64'(exp_lat));
    check_val("mem_accesses", 64'(acc), 64'(exp_acc));
    @(negedge clk);
    check_val("idle_after_resp", 64'(req_ready), 64'd1);
    check_val("rsp_single_pulse", 64'(rsp_valid), 64'd0);
    if (!exp_err && w) begin
      for (int k = 0; k < n; k++) ref_mem[int'(a[8:0]) + k] = wd[8*k +: 8];
      check_val("mem_word_lo", dut_word(a), ref_bytes(a, 4));
      check_val("mem_word_hi", dut_word(a + 64'd4), ref_bytes(a + 64'd4, 4));
    end
  endtask

  initial begin
    logic [63:0] rd, a;
    int          acc_n[2], rsp_n[2], n_acc, n_rsp, r;

    for (int i = 0; i < int'(MemBytes); i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    #1;
    check_val("reset_ready", 64'(req_ready), 64'd1);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("reset_strobes", 64'({mem_read, mem_write}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_req(1'b1, 2'd2, 1'b0, 64'd256, 64'h0000_0000_DEAD_BEEF, rd);
    run_req(1'b0, 2'd2, 1'b0, 64'd256, 64'd0, rd);
    check_val("lw_256", rd, 64'hFFFF_FFFF_DEAD_BEEF);
    run_req(1'b0, 2'd2, 1'b1, 64'd256, 64'd0, rd);
    check_val("lwu_256", rd, 64'h0000_0000_DEAD_BEEF);

    wlog_a.delete(); wlog_d.delete();
    run_req(1'b1, 2'd3, 1'b0, 64'd264, 64'h1122_3344_5566_7788, rd);
    check_val("sd_beats", 64'(wlog_a.size()), 64'd2);
    if (wlog_a.size() == 2) begin
      check_val("sd_addr0", wlog_a[0], 64'd264);
      check_val("sd_data0", wlog_d[0], 64'h5566_7788);
      check_val("sd_addr1", wlog_a[1], 64'd268);
      check_val("sd_data1", wlog_d[1], 64'h1122_3344);
    end
    run_req(1'b0, 2'd3, 1'b0, 64'd264, 64'd0, rd);
    check_val("ld_264", rd, 64'h1122_3344_5566_7788);

    wlog_a.delete(); wlog_d.delete();
    run_req(1'b1, 2'd0, 1'b0, 64'd258, 64'h0000_0000_0000_00AB, rd);
    check_val("sb_beats", 64'(wlog_a.size()), 64'd1);
    if (wlog_a.size() == 1) begin
      check_val("sb_rmw_addr", wlog_a[0], 64'd258);
      check_val("sb_rmw_data", wlog_d[0], 64'h0000_DEAB);
    end
    run_req(1'b0, 2'd2, 1'b0, 64'd256, 64'd0, rd);
    check_val("lw_after_sb", rd, 64'hFFFF_FFFF_DEAB_BEEF);
    run_req(1'b0, 2'd0, 1'b0, 64'd258, 64'd0, rd);
    check_val("lb_258", rd, 64'hFFFF_FFFF_FFFF_FFAB);
    run_req(1'b0, 2'd0, 1'b1, 64'd258, 64'd0, rd);
    check_val("lbu_258", rd, 64'h0000_0000_0000_00AB);

    run_req(1'b0, 2'd2, 1'b0, 64'd509, 64'd0, rd);
    run_req(1'b1, 2'd3, 1'b0, 64'd505, 64'h0123_4567_89AB_CDEF, rd);
    run_req(1'b0, 2'd3, 1'b0, 64'd504, 64'd0, rd);

    // Reset landing in the high beat of a doubleword store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'd272; req_wdata = 64'hAAAA_AAAA_BBBB_BBBB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_val("wrlo_add", mem_add, 64'd272);
    check_val("wrlo_data", write_data, 64'hBBBB_BBBB);
    @(negedge clk);
    check_val("wrhi_write", 64'(mem_write), 64'd1);
    check_val("wrhi_add", mem_add, 64'd276);
    rst = 1'b1;
    #1;
    check_val("rst_ready", 64'(req_ready), 64'd1);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_strobes", 64'({mem_read, mem_write, rsp_valid, rsp_err}), 64'd0);
    check_val("rst_add", mem_add, 64'd0);
    check_val("rst_wdata", write_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[272 + k] = 8'hBB;
    check_val("rst_lo_written", dut_word(64'd272), ref_bytes(64'd272, 4));
    check_val("rst_hi_untouched", dut_word(64'd276), ref_bytes(64'd276, 4));

    // Two loads with req_valid held high throughout.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b1;
    req_addr = 64'd256;
    n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check_val("b2b_busy", 64'(busy), 64'(!req_ready));
      if (rsp_valid && n_rsp < 2) begin
        rsp_n[n_rsp] = c; n_rsp++;
        check_val("b2b_rdata", rsp_rdata, model_load(2'd2, 1'b1, 64'd256));
      end
      if (n_acc == 2 && !req_ready) req_valid = 1'b0;
      if (req_ready && req_valid && n_acc < 2) begin
        acc_n[n_acc] = c; n_acc++;
      end
    end
    req_valid = 1'b0;
    check_val("b2b_accepts", 64'(n_acc), 64'd2);
    check_val("b2b_responses", 64'(n_rsp), 64'd2);
    if (n_acc == 2 && n_rsp == 2) begin
      check_val("b2b_first_lat", 64'(rsp_n[0] - acc_n[0]), 64'd2);
      check_val("b2b_gap", 64'(acc_n[1] - rsp_n[0]), 64'd1);
    end

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = 64'($urandom_range(0, MemBytes + 7));
      else if (r < 8) a = 64'($urandom_range(MemBytes - 12, MemBytes - 1));
      else a = {$urandom, $urandom};
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, {$urandom, $urandom}, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 512, the data-memory size in bytes used for range checking.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1 / req_ready  out  1  pipeline request handshake; a request is accepted when both are high on a rising edge.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-007 req_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
REQ-008 req_addr  in  64 byte address; req_wdata  in  64 store data, LSB-aligned.
REQ-009 rsp_valid  out  1 / rsp_rdata  out  64 / rsp_err  out  1  one-cycle completion pulse, load result, range error.
REQ-010 busy  out  1  pipeline stall, high whenever the FSM is not IDLE.
REQ-011 mem_add  out  64 / write_data  out  64 / mem_write  out  1 / mem_read  out  1  data-memory port; memory writes bytes mem_add..mem_add+3 from write_data[31:0] on the clock edge.
REQ-012 read_data  in  64  data-memory read; combinational in the same cycle; bits [31:0] are bytes mem_add..mem_add+3, little-endian.

Function
REQ-013 FSM states SHALL be IDLE, RD_LO, RD_HI, RMW_RD, RMW_WR, WR_LO, WR_HI, RESP; req_ready = (state==IDLE).
REQ-014 Acceptance SHALL register addr, size, write, unsigned and wdata, then go to: load b/h/w -> RD_LO; load d -> RD_LO; store w/d -> WR_LO; store b/h -> RMW_RD.
REQ-015 Footprint SHALL be 4 bytes for sizes b/h/w and 8 for d; if addr > MEM_BYTES-footprint, the FSM goes directly to RESP with rsp_err=1 and rsp_rdata=0, and no memory strobe is issued.
REQ-016 RD_LO: mem_read=1, mem_add=addr; capture read_data[31:0]; next RD_HI if d, else RESP.
REQ-017 RD_HI: mem_read=1, mem_add=addr+4; capture the upper word; next RESP.
REQ-018 WR_LO: mem_write=1, mem_add=addr, write_data[31:0]=wdata[31:0]; next WR_HI if d, else RESP.
REQ-019 WR_HI: mem_write=1, mem_add=addr+4, write_data[31:0]=wdata[63:32]; next RESP.
REQ-020 RMW_RD: mem_read=1, mem_add=addr; capture the word; RMW_WR: mem_write=1, mem_add=addr, write_data = captured word with [7:0] (b) or [15:0] (h) replaced by wdata; next RESP.
REQ-021 RESP: rsp_valid=1 for exactly one cycle; for loads rsp_rdata = b: word[7:0], h: word[15:0], w: word[31:0], each sign- or zero-extended to 64, d: {hi,lo}; for stores rsp_rdata=0; next IDLE.
REQ-022 Latency from the acceptance edge to rsp_valid SHALL be: error 1 cycle; load or store b/h/w 2 cycles (RMW 3); d 3 cycles.
REQ-023 Back-to-back requests SHALL be accepted no earlier than the cycle after RESP (one IDLE cycle between requests).
REQ-024 mem_read and mem_write SHALL never both be high; outside active states the memory port outputs SHALL be 0.
REQ-025 write_data[63:32] SHALL be 0; address arithmetic SHALL wrap modulo 2^64.
REQ-026 Unaligned addresses SHALL be passed through unchanged (no alignment check).

Reset
REQ-027 reset SHALL immediately force state IDLE and all outputs to 0 except req_ready=1; captured registers are cleared.
REQ-028 Reset mid-operation SHALL abandon the access with no rollback; a doubleword store interrupted in WR_HI leaves the low word written and the high word unwritten.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum, the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the footprint constants.
REQ-030 Sub-module lsu_extend (combinational) SHALL perform load sign/zero extension and the store byte/half merge.

Verification
REQ-031 sw 0xDEADBEEF @256, then lw @256 -> rsp_rdata 0xFFFFFFFF_DEADBEEF, and lwu @256 -> 0x00000000_DEADBEEF; rsp_valid 2 cycles after acceptance.
REQ-032 sd 0x11223344_55667788 @264 -> mem_write at 264 with data 0x55667788, then at 268 with 0x11223344; ld @264 returns the full value with rsp at T+3.
REQ-033 After REQ-031, sb 0xAB @258 -> RMW reads 0x0000DEAD, writes 0x0000DEAB; lw @256 -> 0xFFFFFFFF_DEABBEEF; lb @258 -> 0xFFFFFFFF_FFFFFFAB; lbu @258 -> 0xAB.
REQ-034 lw @509 (MEM_BYTES=512) and sd @505 -> rsp_err=1, rsp_rdata=0, rsp at T+1, with no mem_read or mem_write pulse.
REQ-035 Assert reset during WR_HI of sd 0xAAAAAAAA_BBBBBBBB @272 -> outputs zero in the same cycle, req_ready=1; memory @272 holds 0xBBBBBBBB and @276 is unchanged.
REQ-036 Hold req_valid high for two lw requests -> the second is accepted exactly one cycle after the first RESP, and busy is high throughout each access.
